// File: rtl/soc_mem_pkg.sv
// Shared constants and helpers for the SoC memory responders.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package soc_mem_pkg;

    localparam int          RD_LAT_MAX     = 4;
    localparam logic [31:0] DATA_SRAM_BASE = 32'h1c00_0000;
    localparam int          WSTRB_W        = 4;

    // Word index of a byte address relative to the region base. Callers
    // slice the low bits they need; the upper bits are only meaningful
    // for out-of-range addresses.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return {2'b00, off[31:2]};
    endfunction

    // Replace the byte lanes selected by we; other lanes keep old_w.
    function automatic logic [31:0] byte_merge(input logic [31:0]        old_w,
                                               input logic [31:0]        new_w,
                                               input logic [WSTRB_W-1:0] we);
        logic [31:0] merged;
        merged = old_w;
        for (int i = 0; i < WSTRB_W; i++) begin
            if (we[i]) begin
                merged[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_rd_delay.sv
// Read-response delay line: valid/data shift register RD_LATENCY stages deep.
// Latency: rd_valid rises RD_LATENCY edges after in_vld is sampled; nxt_* lead it by one edge.
// Backpressure: none; advances every cycle, responses can never stall.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low clear of all stages
//   in_vld, in_dat     read accepted this cycle and its word
//   rd_valid           response qualifier for the current cycle
//   nxt_vld, nxt_dat   response that becomes current after the next edge,
//                      so the parent can register rdata in step with rd_valid
module sram_rd_delay #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_vld,
    input  logic [31:0] in_dat,
    output logic        rd_valid,
    output logic        nxt_vld,
    output logic [31:0] nxt_dat
);

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            // The incoming request itself is the next response.
            logic vld_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= in_vld;
                end
            end

            assign rd_valid = vld_q;
            assign nxt_vld  = in_vld;
            assign nxt_dat  = in_dat;
        end else begin : g_latn
            // Data needs only RD_LATENCY-1 stages: the final stage lives in
            // the parent's rdata register.
            logic [RD_LATENCY-1:0] vld_q;
            logic [31:0]           dat_q [RD_LATENCY-1];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    vld_q <= '0;
                    for (int i = 0; i < RD_LATENCY - 1; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q    <= {vld_q[RD_LATENCY-2:0], in_vld};
                    dat_q[0] <= in_dat;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign rd_valid = vld_q[RD_LATENCY-1];
            assign nxt_vld  = vld_q[RD_LATENCY-2];
            assign nxt_dat  = dat_q[RD_LATENCY-2];
        end
    endgenerate

endmodule

// File: rtl/data_sram_responder.sv
// CPU data-SRAM target: byte-enabled word storage, range check with sticky error, access counters.
// Latency: reads return rdata/rd_valid RD_LATENCY edges after the request edge; writes land at the request edge.
// Backpressure: none; one access accepted every cycle en is high, reads fully pipelined.
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   data_sram_en/we/addr/wdata        request: en strobes, we==0 reads, we!=0 writes lanes
//   data_sram_rdata, rd_valid         read data (held between responses) and its one-cycle qualifier
//   err_clr                           clears the sticky error state
//   addr_err, err_addr                sticky out-of-range flag and first offending address
//   rd_cnt, wr_cnt                    saturating accepted-read / accepted-write counts
module data_sram_responder
    import soc_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DATA_SRAM_BASE,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               data_sram_en,
    input  logic [WSTRB_W-1:0] data_sram_we,
    input  logic [31:0]        data_sram_addr,
    input  logic [31:0]        data_sram_wdata,
    output logic [31:0]        data_sram_rdata,
    output logic               rd_valid,
    input  logic               err_clr,
    output logic               addr_err,
    output logic [31:0]        err_addr,
    output logic [31:0]        rd_cnt,
    output logic [31:0]        wr_cnt
);

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > RD_LAT_MAX) begin : g_bad_lat
            $error("data_sram_responder: RD_LATENCY must be within 1..%0d", RD_LAT_MAX);
        end
    endgenerate

    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    // 33-bit bounds so a region ending at 4 GiB cannot wrap the compare.
    localparam logic [32:0] BASE_33 = {1'b0, BASE_ADDR};
    localparam logic [32:0] END_33  = BASE_33 + (33'd4 << DEPTH_LOG2);

    logic [31:0]           mem [DEPTH];

    logic                  is_rd;
    logic                  is_wr;
    logic                  in_range;
    logic [32:0]           addr_33;
    logic [31:0]           widx_full;
    logic [DEPTH_LOG2-1:0] widx;
    logic                  unused_widx_hi;
    logic [31:0]           rd_word;

    logic                  nxt_vld;
    logic [31:0]           nxt_dat;

    logic [31:0]           rdata_q;
    logic                  addr_err_q;
    logic [31:0]           err_addr_q;
    logic [31:0]           rd_cnt_q;
    logic [31:0]           wr_cnt_q;

    assign is_rd    = data_sram_en && (data_sram_we == '0);
    assign is_wr    = data_sram_en && (data_sram_we != '0);
    assign addr_33  = {1'b0, data_sram_addr};
    assign in_range = (addr_33 >= BASE_33) && (addr_33 < END_33);

    // High index bits are nonzero only for out-of-range addresses, which
    // never touch the array.
    assign widx_full      = word_index(data_sram_addr, BASE_ADDR);
    assign widx           = widx_full[DEPTH_LOG2-1:0];
    assign unused_widx_hi = ^widx_full[31:DEPTH_LOG2];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (is_wr && in_range) begin
            mem[widx] <= byte_merge(mem[widx], data_sram_wdata, data_sram_we);
        end
    end

    // Out-of-range reads return zero rather than an aliased word.
    assign rd_word = in_range ? mem[widx] : 32'h0;

    sram_rd_delay #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_delay (
        .clk      (clk),
        .resetn   (resetn),
        .in_vld   (is_rd),
        .in_dat   (rd_word),
        .rd_valid (rd_valid),
        .nxt_vld  (nxt_vld),
        .nxt_dat  (nxt_dat)
    );

    // rdata holds the last response between reads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if (nxt_vld) begin
            rdata_q <= nxt_dat;
        end
    end

    // A new error in the clearing cycle wins over the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_err_q <= 1'b0;
            err_addr_q <= '0;
        end else if (data_sram_en && !in_range && (!addr_err_q || err_clr)) begin
            addr_err_q <= 1'b1;
            err_addr_q <= data_sram_addr;
        end else if (err_clr) begin
            addr_err_q <= 1'b0;
            err_addr_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (is_rd && (rd_cnt_q != '1)) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (is_wr && (wr_cnt_q != '1)) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign addr_err        = addr_err_q;
    assign err_addr        = err_addr_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (RD_LATENCY 1, 2, 3) share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_sram_responder;

    localparam longint BASE_L = 64'h1c00_0000;
    localparam longint SPAN_L = 4 * 4096;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        err_clr = 1'b0;

    logic [31:0] rdata    [3];
    logic        rd_valid [3];
    logic        addr_err [3];
    logic [31:0] err_addr [3];
    logic [31:0] rd_cnt   [3];
    logic [31:0] wr_cnt   [3];

    always #5 clk = ~clk;

    data_sram_responder #(.RD_LATENCY(1)) u_l1 (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata[0]),
        .rd_valid(rd_valid[0]), .err_clr(err_clr), .addr_err(addr_err[0]),
        .err_addr(err_addr[0]), .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0]));

    data_sram_responder #(.RD_LATENCY(2)) u_l2 (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata[1]),
        .rd_valid(rd_valid[1]), .err_clr(err_clr), .addr_err(addr_err[1]),
        .err_addr(err_addr[1]), .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1]));

    data_sram_responder #(.RD_LATENCY(3)) u_l3 (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata[2]),
        .rd_valid(rd_valid[2]), .err_clr(err_clr), .addr_err(addr_err[2]),
        .err_addr(err_addr[2]), .rd_cnt(rd_cnt[2]), .wr_cnt(wr_cnt[2]));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Memory by word index; reads remembered by the edge number that
    // accepted them. Lane l (latency l+1) shows the read accepted l edges ago.
    logic [31:0] m_mem  [int unsigned];
    logic [31:0] m_pend [int];
    int          edge_n = 0;
    logic        m_vld   [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] m_rdata [3] = '{32'h0, 32'h0, 32'h0};
    logic        m_err   = 1'b0;
    logic [31:0] m_eaddr = 32'h0;
    logic [31:0] m_rd    = 32'h0;
    logic [31:0] m_wr    = 32'h0;
    logic        sat_preset = 1'b0;

    longint      m_a;
    logic        m_inr;
    int unsigned m_idx;
    logic [31:0] m_word;

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_pend.delete();
                for (int l = 0; l < 3; l++) begin
                    m_vld[l]   = 1'b0;
                    m_rdata[l] = 32'h0;
                end
                m_err   = 1'b0;
                m_eaddr = 32'h0;
                m_rd    = 32'h0;
                m_wr    = 32'h0;
            end else begin
                edge_n++;
                m_a   = {32'd0, addr};
                m_inr = (m_a >= BASE_L) && (m_a < BASE_L + SPAN_L);
                m_idx = int'((m_a - BASE_L) / 4);
                if (err_clr) begin
                    m_err   = 1'b0;
                    m_eaddr = 32'h0;
                end
                if (en) begin
                    if (!m_inr && !m_err) begin
                        m_err   = 1'b1;
                        m_eaddr = addr;
                    end
                    if (we != 4'h0) begin
                        if (m_wr != 32'hFFFF_FFFF) m_wr++;
                        if (m_inr) begin
                            m_word = m_mem.exists(m_idx) ? m_mem[m_idx] : 32'hx;
                            for (int b = 0; b < 4; b++)
                                if (we[b]) m_word[8*b +: 8] = wdata[8*b +: 8];
                            m_mem[m_idx] = m_word;
                        end
                    end else begin
                        if (m_rd != 32'hFFFF_FFFF) m_rd++;
                        if (!m_inr)                   m_pend[edge_n] = 32'h0;
                        else if (m_mem.exists(m_idx)) m_pend[edge_n] = m_mem[m_idx];
                        else                          m_pend[edge_n] = 32'hx;
                    end
                end
                if (sat_preset) m_rd = 32'hFFFF_FFFE;
                for (int l = 0; l < 3; l++) begin
                    if (m_pend.exists(edge_n - l)) begin
                        m_vld[l]   = 1'b1;
                        m_rdata[l] = m_pend[edge_n - l];
                    end else begin
                        m_vld[l] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic chk_on = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int l = 0; l < 3; l++) begin
                    chk($sformatf("L%0d rd_valid", l + 1), {31'd0, rd_valid[l]}, {31'd0, m_vld[l]});
                    chk($sformatf("L%0d rdata", l + 1),    rdata[l],    m_rdata[l]);
                    chk($sformatf("L%0d addr_err", l + 1), {31'd0, addr_err[l]}, {31'd0, m_err});
                    chk($sformatf("L%0d err_addr", l + 1), err_addr[l], m_eaddr);
                    chk($sformatf("L%0d rd_cnt", l + 1),   rd_cnt[l],   m_rd);
                    chk($sformatf("L%0d wr_cnt", l + 1),   wr_cnt[l],   m_wr);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic c);
        en = e; we = w; addr = a; wdata = d; err_clr = c;
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        drive(1'b1, w, a, d, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a);
        drive(1'b1, 4'h0, a, 32'h0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    logic        v3 [7];
    logic [31:0] d3 [7];
    logic        seen_vld;

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk_on = 1'b1;
        chk("reset rdata",    rdata[0], 32'h0);
        chk("reset rd_valid", {31'd0, rd_valid[2]}, 32'd0);
        chk("reset err_addr", err_addr[1], 32'h0);
        chk("reset rd_cnt",   rd_cnt[0], 32'h0);
        resetn = 1'b1;
        idle();

        // Basic write then read.
        wr(32'h1c00_0010, 32'hDEAD_BEEF, 4'hF);
        rd(32'h1c00_0010);
        chk("basic L1 rd_valid", {31'd0, rd_valid[0]}, 32'd1);
        chk("basic L1 rdata",    rdata[0], 32'hDEAD_BEEF);
        chk("basic L2 early",    {31'd0, rd_valid[1]}, 32'd0);
        chk("basic wr_cnt",      wr_cnt[0], 32'd1);
        chk("basic rd_cnt",      rd_cnt[0], 32'd1);
        idle();
        chk("basic L1 one-shot", {31'd0, rd_valid[0]}, 32'd0);
        chk("basic L1 hold",     rdata[0], 32'hDEAD_BEEF);
        chk("basic L2 rdata",    rdata[1], 32'hDEAD_BEEF);
        idle(); idle();

        // Byte-lane merge.
        wr(32'h1c00_0020, 32'h1122_3344, 4'hF);
        wr(32'h1c00_0020, 32'hAABB_CCDD, 4'b0101);
        rd(32'h1c00_0020);
        chk("merge L1 rdata", rdata[0], 32'h11BB_33DD);
        idle(); idle(); idle();

        // Back-to-back reads observed through the latency-3 instance.
        for (int i = 0; i < 4; i++) wr(32'h1c00_0100 + 32'(4 * i), 32'(i + 1), 4'hF);
        for (int k = 0; k < 7; k++) begin
            if (k < 4) rd(32'h1c00_0100 + 32'(4 * k));
            else       idle();
            v3[k] = rd_valid[2];
            d3[k] = rdata[2];
        end
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("pipe L3 valid step %0d", k), {31'd0, v3[k]},
                (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
            if (k >= 2 && k <= 5) chk($sformatf("pipe L3 data step %0d", k), d3[k], 32'(k - 1));
        end
        idle();

        // Range errors, boundaries and clearing.
        wr(32'h1c00_0000, 32'h1234_5678, 4'hF);
        wr(32'h1c00_3ffc, 32'h5A5A_A5A5, 4'hF);
        wr(32'h1c00_4000, 32'hCAFE_F00D, 4'hF);
        chk("range err set",  {31'd0, addr_err[0]}, 32'd1);
        chk("range err addr", err_addr[0], 32'h1c00_4000);
        rd(32'h1c00_0000);
        chk("range no alias", rdata[0], 32'h1234_5678);
        rd(32'h1c00_3ffc);
        chk("range last word", rdata[0], 32'h5A5A_A5A5);
        rd(32'h0000_0000);
        chk("range oob rdata",  rdata[0], 32'h0);
        chk("range first kept", err_addr[0], 32'h1c00_4000);
        drive(1'b1, 4'h0, 32'h1bff_fffc, 32'h0, 1'b1);
        chk("clr+err flag", {31'd0, addr_err[0]}, 32'd1);
        chk("clr+err addr", err_addr[0], 32'h1bff_fffc);
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("clr flag", {31'd0, addr_err[0]}, 32'd0);
        chk("clr addr", err_addr[0], 32'h0);
        idle(); idle(); idle();

        // Reset with a latency-2 read in flight.
        rd(32'h1c00_0010);
        en = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst L2 rd_valid", {31'd0, rd_valid[1]}, 32'd0);
        chk("rst L1 rd_valid", {31'd0, rd_valid[0]}, 32'd0);
        chk("rst L1 rdata",    rdata[0], 32'h0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        resetn = 1'b1;
        seen_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle();
            seen_vld = seen_vld | rd_valid[1];
        end
        chk("rst no late rsp", {31'd0, seen_vld}, 32'd0);
        chk("rst rd_cnt", rd_cnt[1], 32'h0);
        chk("rst wr_cnt", wr_cnt[1], 32'h0);
        rd(32'h1c00_0010);
        idle();
        chk("rst storage kept", rdata[1], 32'hDEAD_BEEF);
        idle(); idle();

        // Read counter saturation.
        sat_preset = 1'b1;
        force u_l1.rd_cnt_q = 32'hFFFF_FFFE;
        force u_l2.rd_cnt_q = 32'hFFFF_FFFE;
        force u_l3.rd_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk); #1;
        release u_l1.rd_cnt_q;
        release u_l2.rd_cnt_q;
        release u_l3.rd_cnt_q;
        sat_preset = 1'b0;
        chk("sat preset", rd_cnt[0], 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            rd(32'h1c00_0010);
            chk($sformatf("sat rd_cnt %0d", k), rd_cnt[0], 32'hFFFF_FFFF);
        end
        idle(); idle(); idle();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
